// File: rtl/instruction_fetch.sv
// Instruction fetch and decode front end: pairs ROM words with their address, resolves
// jumps/calls/returns into program-counter load requests and keeps a circular return stack.
module instruction_fetch #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    input  logic                   zero_flag,
    output logic                   wr_en,
    output logic                   add_offset,
    output logic [PC_WIDTH-1:0]    counteradress,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    instr_addr,
    output logic [2:0]             stack_depth,
    output logic                   stack_err
);

    localparam int unsigned PtrW     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0]  DepthMax = 3'(STACK_DEPTH);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(STACK_DEPTH - 1);

    logic [PC_WIDTH-1:0] instr_addr_q;
    logic                slot_ok_q, slot_ok_d;
    logic [2:0]          depth_q;
    logic                err_q;
    logic [PtrW-1:0]     sp_q, sp_next, sp_prev;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [3:0]          opcode;
    logic [PC_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0] ret_addr;
    logic                push, pop;

    assign rom_addr    = pc;
    assign instr_addr  = instr_addr_q;
    assign stack_depth = depth_q;
    assign stack_err   = err_q;

    assign opcode   = rom_data[15:12];
    assign imm      = PC_WIDTH'(rom_data[7:0]);
    assign ret_addr = instr_addr_q + PC_WIDTH'(1);
    // sp_q points at the next free slot; when full it also points at the oldest entry
    assign sp_next  = (sp_q == PtrLast) ? '0 : sp_q + PtrW'(1);
    assign sp_prev  = (sp_q == '0) ? PtrLast : sp_q - PtrW'(1);
    assign slot_ok_d = ~wr_en;

    always_comb begin
        wr_en         = 1'b0;
        add_offset    = 1'b0;
        counteradress = '0;
        instr_valid   = 1'b0;
        instr         = '0;
        push          = 1'b0;
        pop           = 1'b0;
        if (slot_ok_q) begin
            unique case (opcode)
                4'hC: begin
                    wr_en         = 1'b1;
                    counteradress = imm;
                end
                4'hD: begin
                    wr_en         = 1'b1;
                    add_offset    = 1'b1;
                    counteradress = imm;
                end
                4'hE: begin
                    if (zero_flag) begin
                        wr_en         = 1'b1;
                        counteradress = imm;
                    end
                end
                4'hF: begin
                    wr_en = 1'b1;
                    if (rom_data[11]) begin
                        pop           = 1'b1;
                        counteradress = (depth_q == '0) ? '0 : stack_q[sp_prev];
                    end else begin
                        push          = 1'b1;
                        counteradress = imm;
                    end
                end
                default: begin
                    instr_valid = 1'b1;
                    instr       = rom_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            instr_addr_q <= '0;
            slot_ok_q    <= 1'b0;
            depth_q      <= '0;
            err_q        <= 1'b0;
            sp_q         <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            instr_addr_q <= pc;
            slot_ok_q    <= slot_ok_d;
            if (push) begin
                stack_q[sp_q] <= ret_addr;
                sp_q          <= sp_next;
                if (depth_q == DepthMax) begin
                    err_q <= 1'b1;
                end else begin
                    depth_q <= depth_q + 3'd1;
                end
            end else if (pop) begin
                if (depth_q == '0) begin
                    err_q <= 1'b1;
                end else begin
                    sp_q    <= sp_prev;
                    depth_q <= depth_q - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a bench-side ROM and program counter close the loop,
// a per-cycle vector table covers the main program, hand sequences cover stack errors and reset.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        res;
    logic [7:0]  pc;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        zero_flag;
    logic        wr_en, add_offset, instr_valid, stack_err;
    logic [7:0]  counteradress, instr_addr;
    logic [15:0] instr;
    logic [2:0]  stack_depth;

    logic [15:0] mem [256];
    int vectors = 0;
    int miscompares = 0;

    instruction_fetch #(.PC_WIDTH(8), .INSTR_WIDTH(16), .STACK_DEPTH(4)) dut (
        .clk          (clk),
        .res          (res),
        .pc           (pc),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .zero_flag    (zero_flag),
        .wr_en        (wr_en),
        .add_offset   (add_offset),
        .counteradress(counteradress),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_addr   (instr_addr),
        .stack_depth  (stack_depth),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    // Program counter and synchronous ROM models
    always @(posedge clk or posedge res) begin
        if (res) pc <= 8'h00;
        else if (wr_en) pc <= add_offset ? pc + counteradress + 8'd1 : counteradress;
        else pc <= pc + 8'd1;
    end
    always @(posedge clk) rom_data <= mem[rom_addr];

    typedef struct {
        logic        zf;
        logic        v;
        logic [15:0] ins;
        logic [7:0]  a;
        logic        w;
        logic        ao;
        logic [7:0]  ca;
        logic [2:0]  d;
        logic        e;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(input logic zf, input logic v, input logic [15:0] ins,
                                input logic [7:0] a, input logic w, input logic ao,
                                input logic [7:0] ca, input logic [2:0] d, input logic e);
        vec_t r;
        r.zf = zf; r.v = v; r.ins = ins; r.a = a; r.w = w; r.ao = ao;
        r.ca = ca; r.d = d; r.e = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        res = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        res = 1'b0;
    endtask

    // Waits for the next redirect and checks its target and the stack state in that slot
    task automatic wait_redirect(input string name, input logic [7:0] ca, input logic [2:0] d,
                                 input logic e);
        int n = 0;
        @(negedge clk); #1;
        while (wr_en !== 1'b1 && n < 12) begin
            @(negedge clk); #1;
            n++;
        end
        if (wr_en !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no redirect within 12 cycles", name);
        end else begin
            chk(name, 64'({counteradress, add_offset, stack_depth, stack_err}),
                64'({ca, 1'b0, d, e}));
        end
    endtask

    logic [7:0] exp_ca [10];
    logic [2:0] exp_d  [10];
    logic       exp_e  [10];

    initial begin
        res = 1'b1;
        zero_flag = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h1000; mem[8'h01] = 16'h1001; mem[8'h02] = 16'hC020;
        mem[8'h20] = 16'hD0F0; mem[8'h12] = 16'h2012; mem[8'h13] = 16'hC010;
        mem[8'h10] = 16'hD008; mem[8'h1A] = 16'h301A; mem[8'h1B] = 16'hE040;
        mem[8'h1C] = 16'hE040; mem[8'h40] = 16'hF030; mem[8'h30] = 16'h5030;
        mem[8'h31] = 16'hF800; mem[8'h41] = 16'h6041; mem[8'h42] = 16'hF800;

        //             zf  v   instr     A      wr  ao  ca     d     e
        tbl[0]  = mk(0, 1, 16'h1000, 8'h00, 0, 0, 8'h00, 3'd0, 0);
        tbl[1]  = mk(0, 1, 16'h1001, 8'h01, 0, 0, 8'h00, 3'd0, 0);
        tbl[2]  = mk(0, 0, 16'h0000, 8'h02, 1, 0, 8'h20, 3'd0, 0);
        tbl[3]  = mk(0, 0, 16'h0000, 8'h03, 0, 0, 8'h00, 3'd0, 0);
        tbl[4]  = mk(0, 0, 16'h0000, 8'h20, 1, 1, 8'hF0, 3'd0, 0);
        tbl[5]  = mk(0, 0, 16'h0000, 8'h21, 0, 0, 8'h00, 3'd0, 0);
        tbl[6]  = mk(0, 1, 16'h2012, 8'h12, 0, 0, 8'h00, 3'd0, 0);
        tbl[7]  = mk(0, 0, 16'h0000, 8'h13, 1, 0, 8'h10, 3'd0, 0);
        tbl[8]  = mk(0, 0, 16'h0000, 8'h14, 0, 0, 8'h00, 3'd0, 0);
        tbl[9]  = mk(0, 0, 16'h0000, 8'h10, 1, 1, 8'h08, 3'd0, 0);
        tbl[10] = mk(0, 0, 16'h0000, 8'h11, 0, 0, 8'h00, 3'd0, 0);
        tbl[11] = mk(0, 1, 16'h301A, 8'h1A, 0, 0, 8'h00, 3'd0, 0);
        tbl[12] = mk(0, 0, 16'h0000, 8'h1B, 0, 0, 8'h00, 3'd0, 0);
        tbl[13] = mk(1, 0, 16'h0000, 8'h1C, 1, 0, 8'h40, 3'd0, 0);
        tbl[14] = mk(0, 0, 16'h0000, 8'h1D, 0, 0, 8'h00, 3'd0, 0);
        tbl[15] = mk(0, 0, 16'h0000, 8'h40, 1, 0, 8'h30, 3'd0, 0);
        tbl[16] = mk(0, 0, 16'h0000, 8'h41, 0, 0, 8'h00, 3'd1, 0);
        tbl[17] = mk(0, 1, 16'h5030, 8'h30, 0, 0, 8'h00, 3'd1, 0);
        tbl[18] = mk(0, 0, 16'h0000, 8'h31, 1, 0, 8'h41, 3'd1, 0);
        tbl[19] = mk(0, 0, 16'h0000, 8'h32, 0, 0, 8'h00, 3'd0, 0);
        tbl[20] = mk(0, 1, 16'h6041, 8'h41, 0, 0, 8'h00, 3'd0, 0);
        tbl[21] = mk(0, 0, 16'h0000, 8'h42, 1, 0, 8'h00, 3'd0, 0);
        tbl[22] = mk(0, 0, 16'h0000, 8'h43, 0, 0, 8'h00, 3'd0, 1);
        tbl[23] = mk(0, 1, 16'h1000, 8'h00, 0, 0, 8'h00, 3'd0, 1);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_outputs", 64'({wr_en, add_offset, counteradress, instr, instr_valid,
                                  instr_addr, stack_depth, stack_err}), 64'd0);
        chk("reset_rom_addr", 64'(rom_addr), 64'(pc));
        @(negedge clk);
        res = 1'b0;
        #1;
        chk("release_squash", 64'({wr_en, instr_valid}), 64'd0);

        // Main program, one record per cycle
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            zero_flag = tbl[i].zf;
            #1;
            chk($sformatf("vec%0d", i + 1),
                64'({instr_valid, instr_valid ? instr : 16'h0000, instr_addr, wr_en,
                     add_offset, counteradress, stack_depth, stack_err}),
                64'({tbl[i].v, tbl[i].ins, tbl[i].a, tbl[i].w, tbl[i].ao, tbl[i].ca,
                     tbl[i].d, tbl[i].e}));
            chk($sformatf("vec%0d_rom_addr", i + 1), 64'(rom_addr), 64'(pc));
        end
        zero_flag = 1'b0;

        // Five nested CALLs (oldest entry lost), four RETs, then RET on an empty stack
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'hF010; mem[8'h10] = 16'hF020; mem[8'h20] = 16'hF030;
        mem[8'h30] = 16'hF040; mem[8'h40] = 16'hF050; mem[8'h50] = 16'hF800;
        mem[8'h41] = 16'hF800; mem[8'h31] = 16'hF800; mem[8'h21] = 16'hF800;
        mem[8'h11] = 16'hF800;
        exp_ca = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h41, 8'h31, 8'h21, 8'h11, 8'h00};
        exp_d  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        exp_e  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wait_redirect($sformatf("stack_redirect%0d", i), exp_ca[i], exp_d[i], exp_e[i]);
        end
        @(negedge clk); #1;
        chk("underflow_after", 64'({stack_depth, stack_err, instr_addr}), 64'({3'd0, 1'b1, 8'h12}));

        // Reset asserted while a CALL is in decode aborts it
        wait_redirect("call_before_abort", 8'h10, 3'd0, 1'b1);
        res = 1'b1;
        #1;
        chk("abort_outputs", 64'({wr_en, add_offset, counteradress, instr, instr_valid,
                                  instr_addr, stack_depth, stack_err}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        res = 1'b0;
        #1;
        chk("abort_squash", 64'({wr_en, instr_valid}), 64'd0);
        @(negedge clk); #1;
        chk("abort_restart", 64'({instr_addr, wr_en, counteradress, stack_depth, stack_err}),
            64'({8'h00, 1'b1, 8'h10, 3'd0, 1'b0}));
        @(negedge clk); #1;
        chk("abort_after_call", 64'({stack_depth, stack_err}), 64'({3'd1, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 8, the program-counter and ROM-address width.
REQ-002 The block SHALL have parameter INSTR_WIDTH, default 16, the instruction word width.
REQ-003 The block SHALL have parameter STACK_DEPTH, default 4, the number of return-address entries.
REQ-004 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 Port res, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port pc, input, PC_WIDTH: current value from the program counter.
REQ-007 Port rom_addr, output, PC_WIDTH: program-ROM address, combinationally equal to pc.
REQ-008 Port rom_data, input, INSTR_WIDTH: registered ROM output, mem[rom_addr of previous cycle].
REQ-009 Port zero_flag, input, 1 bit: execute-stage zero flag, sampled in the decode cycle.
REQ-010 Port wr_en, output, 1 bit: program-counter load request.
REQ-011 Port add_offset, output, 1 bit: program-counter relative-load select (next pc = pc + counteradress + 1).
REQ-012 Port counteradress, output, PC_WIDTH: program-counter load value or offset.
REQ-013 Port instr, output, INSTR_WIDTH: instruction forwarded to execute.
REQ-014 Port instr_valid, output, 1 bit: instr is valid this cycle.
REQ-015 Port instr_addr, output, PC_WIDTH: address of the word currently in decode.
REQ-016 Port stack_depth, output, 3 bits: return-stack occupancy, 0..STACK_DEPTH.
REQ-017 Port stack_err, output, 1 bit: sticky return-stack overflow/underflow flag.

Function
REQ-018 instr_addr SHALL register pc every cycle, so it pairs with rom_data; decode of rom_data SHALL be combinational.
REQ-019 A register slot_ok SHALL be 0 in the cycle after reset release and after any cycle with wr_en=1, and 1 otherwise.
REQ-020 With slot_ok=0, the block SHALL squash the word: instr_valid=0, wr_en=0, no stack change.
REQ-021 Opcodes are rom_data[15:12]; imm = rom_data[7:0]; A = instr_addr.
REQ-022 JMP (0xC): wr_en=1, add_offset=0, counteradress=imm; target = imm.
REQ-023 JMPR (0xD): wr_en=1, add_offset=1, counteradress=imm; target = A+2+imm mod 2^PC_WIDTH, because pc = A+1 in the decode cycle.
REQ-024 JZ (0xE): when zero_flag=1, it SHALL act as JMP; otherwise wr_en=0 and slot_ok stays 1.
REQ-025 CALL (0xF, bit11=0): it SHALL push A+1, increment stack_depth, and act as JMP.
REQ-026 RET (0xF, bit11=1): it SHALL pop the top entry and drive wr_en=1, add_offset=0, with counteradress = the popped entry.
REQ-027 Control-flow opcodes (0xC-0xF) SHALL drive instr_valid=0; every other valid word SHALL drive instr_valid=1 and instr=rom_data.
REQ-028 With wr_en=0, add_offset SHALL be 0 and counteradress SHALL be 0.
REQ-029 CALL with stack_depth=STACK_DEPTH (overflow) SHALL overwrite the oldest entry (circular), keep depth at STACK_DEPTH, and set stack_err.
REQ-030 RET with stack_depth=0 (underflow) SHALL jump to address 0, leave depth 0, and set stack_err.
REQ-031 stack_err SHALL clear only on reset.
REQ-032 Each redirect SHALL cost exactly one squashed cycle; there is no other latency beyond the one-cycle ROM read.

Reset
REQ-033 While res=1, the block SHALL hold slot_ok=0, instr_addr=0, stack_depth=0, stack_err=0, and stack entries=0.
REQ-034 While res=1, all outputs except rom_addr SHALL be 0.
REQ-035 Assertion of res mid-jump or mid-CALL SHALL abort it with no pending state.
REQ-036 After res falls, the first decode slot SHALL be squashed, and fetch SHALL restart from pc.

Verification
REQ-037 Straight-line: ROM 0..3 = 0x1000..0x1003, release res -> instr_valid rises 1 cycle after pc=0; instr/instr_addr = 0x1000/0, 0x1001/1, ... on consecutive cycles.
REQ-038 JMP: mem[2]=0xC020 -> wr_en=1, counteradress=0x20 in slot A=2; next slot squashed; then instr_addr=0x20, instr_valid=1.
REQ-039 JMPR: mem[0x10]=0xD008 -> add_offset=1, counteradress=8; next valid instr_addr=0x1A; for imm=0xF0 at A=0x20, the jump wraps to 0x12.
REQ-040 JZ: mem[5]=0xE040 with zero_flag=0 -> no redirect, instr_addr 6 follows; with zero_flag=1 -> next valid instr_addr=0x40.
REQ-041 CALL/RET: CALL 0x30 at A=4 -> stack_depth=1; RET at 0x31 -> next valid instr_addr=5 and stack_depth=0.
REQ-042 Errors: five nested CALLs -> stack_err=1, depth 4; RET on an empty stack -> target 0; then assert res for 1 cycle mid-sequence -> all outputs 0 and stack_err=0.
